alu_addsub_wb_queue: RTL

Downstream collector for the add/subtract unit. It tracks each accepted add (op 6) or sub (op 7) issue and captures the unit's result, overflow and zero flags exactly one cycle later. Each capture is tagged with the destination register and pushed into a small FIFO. The FIFO drains to the register-file writeback port over a valid/ready handshake and applies back-pressure to the issue logic through `issue_ready`.

---
 rtl/alu_addsub_wb_queue.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_addsub_wb_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_addsub_wb_queue                                           |
// | Captures add/sub results one cycle after issue, queues them with their   |
// | destination tag and drains them to the writeback port.                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module alu_addsub_wb_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic             soc_clk,
   input  logic             reset,
   input  logic             dat_ready,
   input  logic [4:0]       Instruction_to_ALU,
   input  logic [TAG_W-1:0] rd_tag,
   input  logic [31:0]      AddSub_out,
   input  logic             AddSub_overflow,
   input  logic             AddSub_zero,
   output logic             issue_ready,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [31:0]      wb_data,
   output logic [TAG_W-1:0] wb_tag,
   output logic             wb_overflow,
   output logic             wb_zero,
   output logic             wb_sub,
   output logic             drop_err
);

   localparam int                  c_PTR_W   = $clog2(DEPTH);
   localparam int                  c_CNT_W   = c_PTR_W + 1;
   localparam int                  c_ENT_W   = TAG_W + 35;
   localparam logic [c_CNT_W-1:0]  c_FULL    = c_CNT_W'(DEPTH);
   localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);
   localparam logic [c_PTR_W-1:0]  c_PTR_ONE = c_PTR_W'(1);
   localparam logic [4:0]          c_OP_ADD  = 5'd6;
   localparam logic [4:0]          c_OP_SUB  = 5'd7;

   logic                r_pend_valid;
   logic [TAG_W-1:0]    r_pend_tag;
   logic                r_pend_sub;
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_CNT_W-1:0]  r_count;
   logic                r_drop_err;
   logic [c_ENT_W-1:0]  r_mem [DEPTH];

   logic                w_issue;
   logic                w_head_valid;
   logic                w_pop;
   logic                w_full;
   logic                w_wr_en;
   logic [c_CNT_W:0]    w_occupancy;
   logic [c_ENT_W-1:0]  w_head;

   assign w_issue      = dat_ready &&
                         ((Instruction_to_ALU == c_OP_ADD) || (Instruction_to_ALU == c_OP_SUB));
   assign w_head_valid = (r_count != '0);
   assign w_pop        = w_head_valid && wb_ready;
   assign w_full       = (r_count == c_FULL);
   // A full FIFO still accepts the capture when the head leaves on the same edge.
   assign w_wr_en      = r_pend_valid && (!w_full || w_pop);

   // The in-flight result counts as occupied so it always has a slot to land in.
   assign w_occupancy  = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_pend_valid};
   assign issue_ready  = (w_occupancy < {1'b0, c_FULL});

   always_ff @(posedge soc_clk or negedge reset) begin
      if (!reset) begin
         r_pend_valid <= 1'b0;
         r_pend_tag   <= '0;
         r_pend_sub   <= 1'b0;
      end else begin
         r_pend_valid <= w_issue;
         if (w_issue) begin
            r_pend_tag <= rd_tag;
            r_pend_sub <= (Instruction_to_ALU == c_OP_SUB);
         end
      end
   end

   always_ff @(posedge soc_clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_drop_err <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         if (w_wr_en && !w_pop) begin
            r_count <= r_count + c_CNT_ONE;
         end else if (w_pop && !w_wr_en) begin
            r_count <= r_count - c_CNT_ONE;
         end
         if (r_pend_valid && w_full && !w_pop) begin
            r_drop_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge soc_clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= {AddSub_out, AddSub_overflow, AddSub_zero, r_pend_tag, r_pend_sub};
      end
   end

   // Storage is never cleared, so the head is masked while the FIFO is empty.
   assign w_head      = w_head_valid ? r_mem[r_rd_ptr] : '0;

   assign wb_valid    = w_head_valid;
   assign wb_data     = w_head[c_ENT_W-1:TAG_W+3];
   assign wb_overflow = w_head[TAG_W+2];
   assign wb_zero     = w_head[TAG_W+1];
   assign wb_tag      = w_head[TAG_W:1];
   assign wb_sub      = w_head[0];
   assign drop_err    = r_drop_err;

endmodule
`default_nettype wire
